// File: rtl/accel_sample_sequencer.sv
// Periodic three-axis accelerometer sampler: on each sample tick it reads the
// X, Y and Z high bytes over a SPI master handshake, then publishes the
// selected axis (or the largest-magnitude one) with a one-cycle sync pulse.
module accel_sample_sequencer #(
    parameter int unsigned SAMPLE_DIV = 50000,
    parameter int unsigned TIMEOUT    = 1024,
    parameter logic [5:0]  ADDR_X     = 6'h33,
    parameter logic [5:0]  ADDR_Y     = 6'h35,
    parameter logic [5:0]  ADDR_Z     = 6'h37
) (
    input  logic       sys_clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] axis_sel,
    input  logic       err_clr,
    output logic       spi_req,
    output logic [5:0] spi_addr,
    input  logic       spi_done,
    input  logic [7:0] spi_rdata,
    output logic       o_sync,
    output logic [7:0] data,
    output logic       timeout_err,
    output logic       overrun
);

    localparam int unsigned TICK_W = $clog2(SAMPLE_DIV);
    localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(SAMPLE_DIV - 1);
    localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_NEXT,
        ST_PUBLISH
    } state_t;

    typedef enum logic [1:0] {
        AXIS_X,
        AXIS_Y,
        AXIS_Z
    } axis_t;

    // Two's-complement magnitude in 9 bits so that -128 maps to +128.
    function automatic logic [8:0] mag9(input logic [7:0] v);
        return v[7] ? (9'd0 - {1'b1, v}) : {1'b0, v};
    endfunction

    state_t            state_q, state_d;
    axis_t             axis_q, axis_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [7:0]        x_q, x_d, y_q, y_d, z_q, z_d;
    logic [7:0]        data_q, data_d;
    logic              timeout_err_q, timeout_err_d;
    logic              overrun_q, overrun_d;

    logic              tick;
    logic              capture;
    logic              timeout_set;
    logic              overrun_set;
    logic [8:0]        mag_x, mag_y, mag_z;
    logic [7:0]        sel_value;

    assign tick       = (tick_cnt_q == TICK_MAX);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

    // Free-running sample-period divider, independent of enable.
    always_ff @(posedge sys_clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // Axis selection for publishing; axis_sel only matters in PUBLISH.
    always_comb begin
        mag_x = mag9(x_q);
        mag_y = mag9(y_q);
        mag_z = mag9(z_q);
        case (axis_sel)
            2'd0:    sel_value = x_q;
            2'd1:    sel_value = y_q;
            2'd2:    sel_value = z_q;
            default: begin
                // Ties favour X, then Y.
                if (mag_x >= mag_y && mag_x >= mag_z) begin
                    sel_value = x_q;
                end else if (mag_y >= mag_z) begin
                    sel_value = y_q;
                end else begin
                    sel_value = z_q;
                end
            end
        endcase
    end

    // Sequencer next-state logic: read X, Y, Z in turn, then publish.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d     = state_q;
        axis_d      = axis_q;
        to_cnt_d    = to_cnt_q;
        data_d      = data_q;
        capture     = 1'b0;
        timeout_set = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tick && enable) begin
                    state_d = ST_REQ;
                    axis_d  = AXIS_X;
                end
            end
            ST_REQ: begin
                to_cnt_d = '0;
                if (spi_done) begin
                    capture = 1'b1;
                    state_d = ST_NEXT;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (spi_done) begin
                    capture = 1'b1;
                    state_d = ST_NEXT;
                end else if (to_cnt_q == TO_MAX) begin
                    // Abandon the whole sample; published data is untouched.
                    timeout_set = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_NEXT: begin
                case (axis_q)
                    AXIS_X: begin
                        axis_d  = AXIS_Y;
                        state_d = ST_REQ;
                    end
                    AXIS_Y: begin
                        axis_d  = AXIS_Z;
                        state_d = ST_REQ;
                    end
                    default: begin
                        state_d = ST_PUBLISH;
                    end
                endcase
            end
            ST_PUBLISH: begin
                data_d  = sel_value;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Route an accepted read byte into the register of the axis being read.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        z_d = z_q;
        if (capture) begin
            case (axis_q)
                AXIS_X:  x_d = spi_rdata;
                AXIS_Y:  y_d = spi_rdata;
                default: z_d = spi_rdata;
            endcase
        end
    end

    // Sticky error flags: a set event in the same cycle beats err_clr.
    always_comb begin
        overrun_set   = tick && (state_q != ST_IDLE);
        timeout_err_d = timeout_set ? 1'b1 : (err_clr ? 1'b0 : timeout_err_q);
        overrun_d     = overrun_set ? 1'b1 : (err_clr ? 1'b0 : overrun_q);
    end

    // Sequencer state, axis samples, published value and flags.
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            axis_q        <= AXIS_X;
            to_cnt_q      <= '0;
            x_q           <= 8'h00;
            y_q           <= 8'h00;
            z_q           <= 8'h00;
            data_q        <= 8'h00;
            timeout_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            axis_q        <= axis_d;
            to_cnt_q      <= to_cnt_d;
            x_q           <= x_d;
            y_q           <= y_d;
            z_q           <= z_d;
            data_q        <= data_d;
            timeout_err_q <= timeout_err_d;
            overrun_q     <= overrun_d;
        end
    end

    // Moore outputs; the address parks on ADDR_X whenever no read is open.
    always_comb begin
        spi_req  = (state_q == ST_REQ) || (state_q == ST_WAIT);
        spi_addr = ADDR_X;
        if (spi_req) begin
            case (axis_q)
                AXIS_X:  spi_addr = ADDR_X;
                AXIS_Y:  spi_addr = ADDR_Y;
                default: spi_addr = ADDR_Z;
            endcase
        end
        o_sync      = (state_q == ST_PUBLISH);
        // The new value is visible in the PUBLISH cycle itself, alongside o_sync.
        data        = o_sync ? sel_value : data_q;
        timeout_err = timeout_err_q;
        overrun     = overrun_q;
    end

endmodule

// File: tb/tb_accel_sample_sequencer.sv
// Directed bench for accel_sample_sequencer with a behavioural SPI responder
// and a bus monitor that records request windows and publish events.
module tb_accel_sample_sequencer;

    localparam int unsigned SAMPLE_DIV = 16;
    localparam int unsigned TIMEOUT    = 8;
    localparam logic [5:0]  ADDR_X     = 6'h33;
    localparam logic [5:0]  ADDR_Y     = 6'h35;
    localparam logic [5:0]  ADDR_Z     = 6'h37;

    logic       sys_clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] axis_sel;
    logic       err_clr;
    logic       spi_req;
    logic [5:0] spi_addr;
    logic       spi_done;
    logic [7:0] spi_rdata;
    logic       o_sync;
    logic [7:0] data;
    logic       timeout_err;
    logic       overrun;

    logic       resp_done  = 1'b0;
    logic [7:0] resp_rdata = 8'h00;
    logic       man_done   = 1'b0;
    logic [7:0] man_rdata  = 8'h00;

    // Responder configuration, written only by the main sequence.
    int         resp_lat = 3;
    logic       skip_y   = 1'b0;
    logic [7:0] rx = 8'h00, ry = 8'h00, rz = 8'h00;

    // Monitor records, written only by the monitor process.
    int         cyc = 0;
    int         sync_cnt = 0, sync_cyc = 0, done_cyc = 0;
    logic [7:0] sync_data = 8'h00;
    int         win_cnt = 0, cur_len = 0;
    logic [5:0] win_addr [256];
    int         win_len  [256];
    int         addr_viol = 0, addr_unstable = 0;
    logic       prev_req = 1'b0;
    logic [5:0] prev_addr = 6'h00;

    int n_checks = 0;
    int n_fail   = 0;

    assign spi_done  = resp_done | man_done;
    assign spi_rdata = man_done ? man_rdata : resp_rdata;

    always #5 sys_clock = ~sys_clock;

    accel_sample_sequencer #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .TIMEOUT    (TIMEOUT),
        .ADDR_X     (ADDR_X),
        .ADDR_Y     (ADDR_Y),
        .ADDR_Z     (ADDR_Z)
    ) dut (
        .sys_clock   (sys_clock),
        .reset       (reset),
        .enable      (enable),
        .axis_sel    (axis_sel),
        .err_clr     (err_clr),
        .spi_req     (spi_req),
        .spi_addr    (spi_addr),
        .spi_done    (spi_done),
        .spi_rdata   (spi_rdata),
        .o_sync      (o_sync),
        .data        (data),
        .timeout_err (timeout_err),
        .overrun     (overrun)
    );

    // Monitor and SPI responder; samples on the falling edge, mid-cycle.
    initial begin
        forever begin
            @(negedge sys_clock);
            cyc++;
            if (o_sync === 1'b1) begin
                sync_cnt++;
                sync_data = data;
                sync_cyc  = cyc;
            end
            if (spi_req === 1'b1) begin
                if (!prev_req) begin
                    win_addr[win_cnt % 256] = spi_addr;
                    win_cnt++;
                    cur_len = 1;
                end else begin
                    cur_len++;
                    if (spi_addr != prev_addr) addr_unstable++;
                end
            end else begin
                if (prev_req) win_len[(win_cnt - 1) % 256] = cur_len;
                cur_len = 0;
                if (spi_addr !== ADDR_X) addr_viol++;
            end
            prev_req  = (spi_req === 1'b1);
            prev_addr = spi_addr;

            resp_done = 1'b0;
            if (spi_req === 1'b1 && cur_len == resp_lat &&
                !(skip_y && spi_addr == ADDR_Y)) begin
                resp_done = 1'b1;
                done_cyc  = cyc;
                case (spi_addr)
                    ADDR_X:  resp_rdata = rx;
                    ADDR_Y:  resp_rdata = ry;
                    default: resp_rdata = rz;
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(negedge sys_clock);
        #1;
    endtask

    task automatic wait_sync(input string tag, input int budget);
        int base;
        int n;
        base = sync_cnt;
        n    = 0;
        while (sync_cnt == base && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(sync_cnt - base), 32'd1);
    endtask

    task automatic wait_windows(input string tag, input int base, input int count,
                                input int budget);
        int n;
        n = 0;
        while ((win_cnt - base) < count && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(win_cnt - base), 32'(count));
    endtask

    initial begin
        int sb;
        int wb;
        int n;

        reset    = 1'b1;
        enable   = 1'b0;
        axis_sel = 2'd0;
        err_clr  = 1'b0;
        repeat (2) step();
        reset = 1'b0;

        // Reset state.
        check("rst_spi_req",     32'(spi_req),     32'd0);
        check("rst_spi_addr",    32'(spi_addr),    32'h33);
        check("rst_o_sync",      32'(o_sync),      32'd0);
        check("rst_data",        32'(data),        32'h00);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_overrun",     32'(overrun),     32'd0);

        // Nominal: Y selected, 3-cycle responder.
        enable = 1'b1; axis_sel = 2'd1; resp_lat = 3;
        rx = 8'h10; ry = 8'hF0; rz = 8'h05;
        sb = sync_cnt; wb = win_cnt;
        wait_sync("nom_sync", 40);
        check("nom_data",    32'(sync_data), 32'hF0);
        check("nom_latency", 32'(sync_cyc - done_cyc), 32'd2);
        check("nom_windows", 32'(win_cnt - wb), 32'd3);
        check("nom_addr_x",  32'(win_addr[wb % 256]), 32'h33);
        check("nom_addr_y",  32'(win_addr[(wb + 1) % 256]), 32'h35);
        check("nom_addr_z",  32'(win_addr[(wb + 2) % 256]), 32'h37);
        check("nom_len_x",   32'(win_len[wb % 256]), 32'd3);
        step(); step();
        check("nom_one_sync",    32'(sync_cnt - sb), 32'd1);
        check("nom_data_held",   32'(data),          32'hF0);
        check("nom_timeout_err", 32'(timeout_err),   32'd0);
        check("nom_overrun",     32'(overrun),       32'd0);

        // Largest magnitude: |-128| beats 127.
        axis_sel = 2'd3;
        rx = 8'h80; ry = 8'h7F; rz = 8'h00;
        wait_sync("magA_sync", 40);
        check("magA_data", 32'(sync_data), 32'h80);
        step(); step();

        // Largest magnitude tie goes to X; enable drops mid-sequence.
        rx = 8'h40; ry = 8'hC0; rz = 8'h01;
        wb = win_cnt;
        wait_windows("magB_started", wb, 1, 30);
        enable = 1'b0;
        wait_sync("magB_sync", 40);
        check("magB_data",    32'(sync_data), 32'h40);
        check("magB_windows", 32'(win_cnt - wb), 32'd3);
        enable = 1'b1;
        step(); step();

        // Timeout on the Y read.
        skip_y = 1'b1;
        sb = sync_cnt; wb = win_cnt;
        wait_windows("to_restart", wb, 3, 50);
        check("to_flag",        32'(timeout_err), 32'd1);
        check("to_no_sync",     32'(sync_cnt - sb), 32'd0);
        check("to_data_kept",   32'(data), 32'h40);
        check("to_y_addr",      32'(win_addr[(wb + 1) % 256]), 32'h35);
        check("to_y_len",       32'(win_len[(wb + 1) % 256]), 32'd9);
        check("to_restart_x",   32'(win_addr[(wb + 2) % 256]), 32'h33);
        check("to_overrun",     32'(overrun), 32'd0);

        // Reset mid-WAIT, late spi_done, then first-tick distance.
        skip_y = 1'b0; resp_lat = 6; axis_sel = 2'd0;
        rx = 8'h22; ry = 8'h33; rz = 8'h44;
        step();
        check("rstw_pre_req", 32'(spi_req), 32'd1);
        check("rstw_pre_len", 32'(cur_len), 32'd2);
        sb = sync_cnt;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstw_spi_req",     32'(spi_req),     32'd0);
        check("rstw_spi_addr",    32'(spi_addr),    32'h33);
        check("rstw_o_sync",      32'(o_sync),      32'd0);
        check("rstw_data",        32'(data),        32'h00);
        check("rstw_timeout_err", 32'(timeout_err), 32'd0);
        check("rstw_overrun",     32'(overrun),     32'd0);
        man_rdata = 8'h55; man_done = 1'b1;
        step();
        man_done = 1'b0;
        n = 1;
        check("rstw_late_done_req", 32'(spi_req), 32'd0);
        while (spi_req !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("rstw_first_tick", 32'(n), 32'd16);
        check("rstw_no_sync",    32'(sync_cnt - sb), 32'd0);
        check("rstw_data_still", 32'(data), 32'h00);

        // Overrun: 6-cycle reads stretch the sequence past one tick period.
        wb = win_cnt - 1;
        wait_sync("ovr_sync", 60);
        check("ovr_flag",    32'(overrun), 32'd1);
        check("ovr_data",    32'(sync_data), 32'h22);
        check("ovr_windows", 32'(win_cnt - wb), 32'd3);
        check("ovr_latency", 32'(sync_cyc - done_cyc), 32'd2);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'd0);

        // Sampling disabled for three tick periods.
        enable = 1'b0;
        sb = sync_cnt; wb = win_cnt;
        repeat (3 * SAMPLE_DIV + 4) step();
        check("dis_windows", 32'(win_cnt - wb), 32'd0);
        check("dis_no_sync", 32'(sync_cnt - sb), 32'd0);
        check("dis_spi_req", 32'(spi_req), 32'd0);

        // Bus rules observed across the whole run.
        check("addr_idle_is_x",  32'(addr_viol),     32'd0);
        check("addr_stable_req", 32'(addr_unstable), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
